// File: rtl/uart_axil_arbiter.sv
// Round-robin arbiter between two MMIO requesters for the UART AXI4-Lite slave.
// Runs one transaction at a time and turns stalled B/R responses into error responses.
module uart_axil_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic                req0_we_i,
    input  logic [ADDR_W-1:0]   req0_addr_i,
    input  logic [DATA_W-1:0]   req0_wdata_i,
    input  logic [DATA_W/8-1:0] req0_wstrb_i,
    output logic                rsp0_valid_o,
    output logic [DATA_W-1:0]   rsp0_rdata_o,
    output logic                rsp0_err_o,

    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic                req1_we_i,
    input  logic [ADDR_W-1:0]   req1_addr_i,
    input  logic [DATA_W-1:0]   req1_wdata_i,
    input  logic [DATA_W/8-1:0] req1_wstrb_i,
    output logic                rsp1_valid_o,
    output logic [DATA_W-1:0]   rsp1_rdata_o,
    output logic                rsp1_err_o,

    output logic [ADDR_W-1:0]   m_axi_uart_awaddr,
    output logic                m_axi_uart_awvalid,
    input  logic                m_axi_uart_awready,
    output logic [DATA_W-1:0]   m_axi_uart_wdata,
    output logic [DATA_W/8-1:0] m_axi_uart_wstrb,
    output logic                m_axi_uart_wvalid,
    input  logic                m_axi_uart_wready,
    input  logic [1:0]          m_axi_uart_bresp,
    input  logic                m_axi_uart_bvalid,
    output logic                m_axi_uart_bready,
    output logic [ADDR_W-1:0]   m_axi_uart_araddr,
    output logic                m_axi_uart_arvalid,
    input  logic                m_axi_uart_arready,
    input  logic [DATA_W-1:0]   m_axi_uart_rdata,
    input  logic [1:0]          m_axi_uart_rresp,
    input  logic                m_axi_uart_rvalid,
    output logic                m_axi_uart_rready
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                last_q, id_q, err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [15:0]         cnt_q;
    logic                pend_b_q, pend_r_q, pend_b_d, pend_r_d;
    logic                bready_d, rready_d;
    logic                gnt_any, gnt_id, gnt_we;
    logic                b_hs, r_hs, aw_open, w_open, timeout;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_wdata;
    logic [DATA_W/8-1:0] gnt_wstrb;
    logic                unused_resp_bits;

    assign unused_resp_bits = ^{m_axi_uart_bresp[0], m_axi_uart_rresp[0]};

    assign b_hs    = m_axi_uart_bvalid & m_axi_uart_bready;
    assign r_hs    = m_axi_uart_rvalid & m_axi_uart_rready;
    assign aw_open = m_axi_uart_awvalid & ~m_axi_uart_awready;
    assign w_open  = m_axi_uart_wvalid & ~m_axi_uart_wready;
    assign timeout = (cnt_q == TO_LAST);

    // A late response from a timed-out transaction must be absorbed before any new grant.
    assign gnt_any   = (req0_valid_i | req1_valid_i) & ~pend_b_q & ~pend_r_q;
    assign gnt_id    = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;
    assign gnt_we    = gnt_id ? req1_we_i    : req0_we_i;
    assign gnt_addr  = gnt_id ? req1_addr_i  : req0_addr_i;
    assign gnt_wdata = gnt_id ? req1_wdata_i : req0_wdata_i;
    assign gnt_wstrb = gnt_id ? req1_wstrb_i : req0_wstrb_i;

    assign req0_ready_o = (state_q == IDLE) & gnt_any & ~gnt_id;
    assign req1_ready_o = (state_q == IDLE) & gnt_any &  gnt_id;

    assign rsp0_valid_o = (state_q == RESP) & ~id_q;
    assign rsp1_valid_o = (state_q == RESP) &  id_q;
    assign rsp0_rdata_o = id_q ? '0 : rdata_q;
    assign rsp1_rdata_o = id_q ? rdata_q : '0;
    assign rsp0_err_o   = ~id_q & err_q;
    assign rsp1_err_o   =  id_q & err_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_any) state_d = gnt_we ? WADDR : RADDR;
            WADDR:   if (!aw_open && !w_open) state_d = WRESP;
            WRESP:   if (b_hs) state_d = RESP; else if (timeout) state_d = DRAIN;
            RADDR:   if (m_axi_uart_arready) state_d = RDATA;
            RDATA:   if (r_hs) state_d = RESP; else if (timeout) state_d = DRAIN;
            RESP:    state_d = IDLE;
            DRAIN:   state_d = RESP;
            default: state_d = IDLE;
        endcase
        pend_b_d = pend_b_q ? ~b_hs : ((state_q == WRESP) & ~b_hs & timeout);
        pend_r_d = pend_r_q ? ~r_hs : ((state_q == RDATA) & ~r_hs & timeout);
        bready_d = (state_d == WRESP) | pend_b_d;
        rready_d = (state_d == RDATA) | pend_r_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= IDLE;
            last_q             <= 1'b1;
            id_q               <= 1'b0;
            err_q              <= 1'b0;
            rdata_q            <= '0;
            cnt_q              <= '0;
            pend_b_q           <= 1'b0;
            pend_r_q           <= 1'b0;
            m_axi_uart_awaddr  <= '0;
            m_axi_uart_awvalid <= 1'b0;
            m_axi_uart_wdata   <= '0;
            m_axi_uart_wstrb   <= '0;
            m_axi_uart_wvalid  <= 1'b0;
            m_axi_uart_bready  <= 1'b0;
            m_axi_uart_araddr  <= '0;
            m_axi_uart_arvalid <= 1'b0;
            m_axi_uart_rready  <= 1'b0;
        end else begin
            state_q           <= state_d;
            pend_b_q          <= pend_b_d;
            pend_r_q          <= pend_r_d;
            m_axi_uart_bready <= bready_d;
            m_axi_uart_rready <= rready_d;
            cnt_q <= (state_q == WRESP || state_q == RDATA) ? cnt_q + 16'd1 : '0;

            if (m_axi_uart_awready) m_axi_uart_awvalid <= 1'b0;
            if (m_axi_uart_wready)  m_axi_uart_wvalid  <= 1'b0;
            if (m_axi_uart_arready) m_axi_uart_arvalid <= 1'b0;

            unique case (state_q)
                IDLE: if (gnt_any) begin
                    id_q    <= gnt_id;
                    last_q  <= gnt_id;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    if (gnt_we) begin
                        m_axi_uart_awaddr  <= gnt_addr;
                        m_axi_uart_wdata   <= gnt_wdata;
                        m_axi_uart_wstrb   <= gnt_wstrb;
                        m_axi_uart_awvalid <= 1'b1;
                        m_axi_uart_wvalid  <= 1'b1;
                    end else begin
                        m_axi_uart_araddr  <= gnt_addr;
                        m_axi_uart_arvalid <= 1'b1;
                    end
                end
                WRESP: begin
                    if (b_hs) err_q <= m_axi_uart_bresp[1];
                    else if (timeout) err_q <= 1'b1;
                end
                RDATA: begin
                    if (r_hs) begin
                        err_q   <= m_axi_uart_rresp[1];
                        rdata_q <= m_axi_uart_rresp[1] ? '0 : m_axi_uart_rdata;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_axil_arbiter.sv
// Directed bench for uart_axil_arbiter: table of single transactions against a
// zero-wait slave, plus split AW/W, timeout/drain, mid-transaction reset and contention.
module tb_uart_axil_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req0_valid_i = 0, req0_we_i = 0, req1_valid_i = 0, req1_we_i = 0;
    logic [12:0] req0_addr_i = '0, req1_addr_i = '0;
    logic [31:0] req0_wdata_i = '0, req1_wdata_i = '0;
    logic [3:0]  req0_wstrb_i = '0, req1_wstrb_i = '0;
    logic        req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_err_o, rsp1_err_o;
    logic [31:0] rsp0_rdata_o, rsp1_rdata_o;
    logic [12:0] awaddr, araddr;
    logic [31:0] wdata, rdata = '0;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]  bresp = '0, rresp = '0;

    int n_checks = 0;
    int n_errors = 0;

    uart_axil_arbiter #(.ADDR_W(13), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
        .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i), .req0_wstrb_i(req0_wstrb_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o), .rsp0_err_o(rsp0_err_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
        .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i), .req1_wstrb_i(req1_wstrb_i),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o), .rsp1_err_o(rsp1_err_o),
        .m_axi_uart_awaddr(awaddr), .m_axi_uart_awvalid(awvalid), .m_axi_uart_awready(awready),
        .m_axi_uart_wdata(wdata), .m_axi_uart_wstrb(wstrb), .m_axi_uart_wvalid(wvalid),
        .m_axi_uart_wready(wready), .m_axi_uart_bresp(bresp), .m_axi_uart_bvalid(bvalid),
        .m_axi_uart_bready(bready), .m_axi_uart_araddr(araddr), .m_axi_uart_arvalid(arvalid),
        .m_axi_uart_arready(arready), .m_axi_uart_rdata(rdata), .m_axi_uart_rresp(rresp),
        .m_axi_uart_rvalid(rvalid), .m_axi_uart_rready(rready)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        id;
        logic        we;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic id, input logic we, input logic [12:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws);
        if (id) begin
            req1_valid_i = 1; req1_we_i = we; req1_addr_i = addr; req1_wdata_i = wd; req1_wstrb_i = ws;
        end else begin
            req0_valid_i = 1; req0_we_i = we; req0_addr_i = addr; req0_wdata_i = wd; req0_wstrb_i = ws;
        end
    endtask

    task automatic clear_reqs();
        req0_valid_i = 0; req1_valid_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    // One transaction against a zero-wait slave; entered and left 1 time unit after a rising edge.
    task automatic run_txn(input vec_t v);
        set_req(v.id, v.we, v.addr, v.wdata, v.wstrb);
        @(negedge clk_i);
        check("txn_grant_ready", v.id ? req1_ready_o : req0_ready_o, 1);
        check("txn_other_ready", v.id ? req0_ready_o : req1_ready_o, 0);
        next_cycle();
        clear_reqs();
        @(negedge clk_i);
        if (v.we) begin
            check("txn_aw_w_valid", {awvalid, wvalid, arvalid}, 3'b110);
            check("txn_awaddr", awaddr, v.addr);
            check("txn_wdata", wdata, v.wdata);
            check("txn_wstrb", wstrb, v.wstrb);
            awready = 1; wready = 1;
        end else begin
            check("txn_ar_valid", {awvalid, wvalid, arvalid}, 3'b001);
            check("txn_araddr", araddr, v.addr);
            arready = 1;
        end
        next_cycle();
        awready = 0; wready = 0; arready = 0;
        if (v.we) begin bvalid = 1; bresp = v.s_resp; end
        else begin rvalid = 1; rdata = v.s_rdata; rresp = v.s_resp; end
        @(negedge clk_i);
        check("txn_resp_ready", {bready, rready}, v.we ? 2'b10 : 2'b01);
        check("txn_addr_valids_low", {awvalid, wvalid, arvalid}, 0);
        check("txn_no_early_rsp", {rsp0_valid_o, rsp1_valid_o}, 0);
        next_cycle();
        bvalid = 0; rvalid = 0; rdata = '0; bresp = '0; rresp = '0;
        @(negedge clk_i);
        check("txn_rsp_valid", {rsp1_valid_o, rsp0_valid_o}, v.id ? 2'b10 : 2'b01);
        check("txn_rsp_rdata", v.id ? rsp1_rdata_o : rsp0_rdata_o, v.exp_rdata);
        check("txn_rsp_err", v.id ? rsp1_err_o : rsp0_err_o, v.exp_err);
        next_cycle();
        @(negedge clk_i);
        check("txn_rsp_single_pulse", {rsp0_valid_o, rsp1_valid_o}, 0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, n_errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int grants, rsps;
        logic r_next;
        logic [31:0] r_data_next;

        //          id  we  addr     wdata         wstrb  s_rdata       s_resp exp_rdata     exp_err
        vecs[0] = '{0, 1, 13'h004, 32'h41,       4'hF, 32'h0,        2'b00, 32'h0,        0};
        vecs[1] = '{1, 0, 13'h008, 32'h0,        4'h0, 32'h60,       2'b00, 32'h60,       0};
        vecs[2] = '{0, 0, 13'h00C, 32'h0,        4'h0, 32'hDEAD,     2'b10, 32'h0,        1};
        vecs[3] = '{1, 1, 13'h010, 32'h12345678, 4'h3, 32'h0,        2'b11, 32'h0,        1};
        vecs[4] = '{0, 0, 13'h1FFC, 32'h0,       4'h0, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFF, 0};
        vecs[5] = '{1, 1, 13'h1FFC, 32'hA5A5A5A5, 4'h8, 32'h0,       2'b01, 32'h0,        0};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        @(negedge clk_i);
        check("rst_ready", {req0_ready_o, req1_ready_o}, 0);
        check("rst_axi_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_rsp", {rsp0_valid_o, rsp1_valid_o, rsp0_err_o, rsp1_err_o}, 0);
        check("rst_rdata", rsp0_rdata_o | rsp1_rdata_o, 0);
        check("rst_axi_addr_data", {awaddr, araddr, wstrb}, 0);
        check("rst_wdata", wdata, 0);
        next_cycle();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Split AW/W: wready immediate, awready only on the third cycle of awvalid
        set_req(0, 1, 13'h004, 32'h42, 4'h1);
        @(negedge clk_i);
        check("split_ready", req0_ready_o, 1);
        next_cycle();
        clear_reqs();
        @(negedge clk_i);
        check("split_both_valid", {awvalid, wvalid}, 2'b11);
        wready = 1;
        next_cycle();
        wready = 0;
        @(negedge clk_i);
        check("split_c2_valids", {awvalid, wvalid, bready}, 3'b100);
        next_cycle();
        @(negedge clk_i);
        check("split_c3_valids", {awvalid, wvalid, bready}, 3'b100);
        awready = 1;
        next_cycle();
        awready = 0; bvalid = 1; bresp = 2'b00;
        @(negedge clk_i);
        check("split_wresp_entry", {awvalid, wvalid, bready}, 3'b001);
        next_cycle();
        bvalid = 0;
        @(negedge clk_i);
        check("split_rsp", {rsp0_valid_o, rsp0_err_o, rsp1_valid_o}, 3'b100);
        check("split_rdata", rsp0_rdata_o, 0);
        next_cycle();

        // Timeout: bvalid withheld 40 cycles after WRESP entry (k=0), then a normal read
        set_req(1, 1, 13'h020, 32'h55, 4'hF);
        @(negedge clk_i);
        check("to_grant", req1_ready_o, 1);
        next_cycle();
        clear_reqs();
        @(negedge clk_i);
        awready = 1; wready = 1;
        for (int k = 0; k <= 45; k++) begin
            next_cycle();
            awready = 0; wready = 0; arready = 0;
            bvalid = (k == 40);
            rvalid = (k == 43);
            rdata  = (k == 43) ? 32'h77 : 32'h0;
            if (k == 30) set_req(0, 0, 13'h030, 32'h0, 4'h0);
            if (k == 42) clear_reqs();
            @(negedge clk_i);
            check("to_rsp1_valid", rsp1_valid_o, k == 17);
            check("to_rsp0_valid", rsp0_valid_o, k == 44);
            check("to_bready", bready, k <= 40);
            if (k == 17) check("to_err_rsp", {rsp1_err_o, rsp1_rdata_o}, 33'h1_0000_0000);
            if (k == 44) check("to_next_read", {rsp0_err_o, rsp0_rdata_o}, 33'h0_0000_0077);
            if (k >= 30 && k <= 41) check("to_grant_held", req0_ready_o, k == 41);
            if (k == 42) begin
                check("to_next_arvalid", arvalid, 1);
                check("to_next_araddr", araddr, 13'h030);
                arready = 1;
            end
        end
        next_cycle();

        // Reset in the middle of a read: no response, valids dropped the cycle after
        set_req(0, 0, 13'h0AB, 32'h0, 4'h0);
        next_cycle();
        clear_reqs();
        @(negedge clk_i);
        check("mid_arvalid", arvalid, 1);
        next_cycle();
        rst_i = 1;
        next_cycle();
        rst_i = 0;
        @(negedge clk_i);
        check("mid_rst_valids", {arvalid, rready, rsp0_valid_o, rsp1_valid_o}, 0);
        check("mid_rst_araddr", araddr, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk_i);
            check("mid_no_rsp", {rsp0_valid_o, rsp1_valid_o, arvalid}, 0);
        end
        next_cycle();

        // Contention: both reading continuously, requester 0 first after reset
        grants = 0; rsps = 0; r_next = 0; r_data_next = '0;
        set_req(0, 0, 13'h100, 32'h0, 4'h0);
        set_req(1, 0, 13'h200, 32'h0, 4'h0);
        for (int c = 0; c < 60 && rsps < 4; c++) begin
            @(negedge clk_i);
            if (req0_ready_o || req1_ready_o) begin
                check("cont_single_ready", req0_ready_o & req1_ready_o, 0);
                check("cont_no_outstanding", 32'(grants - rsps), 0);
                check("cont_order", req1_ready_o, 32'(grants % 2));
                grants++;
            end
            if (rsp0_valid_o || rsp1_valid_o) begin
                check("cont_rsp_rdata", rsp0_valid_o ? rsp0_rdata_o : rsp1_rdata_o,
                      rsp0_valid_o ? 32'h100 : 32'h200);
                check("cont_rsp_order", rsp1_valid_o, 32'(rsps % 2));
                rsps++;
                if (rsps == 4) clear_reqs();
            end
            rvalid = r_next;
            rdata = r_data_next;
            r_next = arvalid;
            r_data_next = {19'b0, araddr};
            arready = arvalid;
            @(posedge clk_i);
        end
        check("cont_grants", grants, 4);
        check("cont_rsps", rsps, 4);
        rvalid = 0; arready = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
